// File: rtl/fir_coe_pkg.sv
// fir_coe_pkg: shared state encoding, default sizes and tap-count helper for the coefficient sender
package fir_coe_pkg;
  typedef enum logic [2:0] {IDLE, SEND, GAP, LOAD, HOLD} state_t;
  localparam int COE_NUM_DEF = 51;
  localparam int COE_WDTH_DEF = 29;
  function automatic int coe_half(input int n);
    return (n + 1) / 2;
  endfunction
endpackage

// File: rtl/fir_coe_send_if.sv
// fir_coe_send_if: host-side write/start inputs and reload-receiver outputs of the coefficient sender
interface fir_coe_send_if import fir_coe_pkg::*; #(
  parameter int COE_NUM = COE_NUM_DEF,
  parameter int COE_WDTH = COE_WDTH_DEF
);
  localparam int ADDR_W = $clog2(coe_half(COE_NUM));
  logic host_wr_en;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [COE_WDTH-1:0] host_wr_data;
  logic [31:0] host_dec;
  logic host_start;
  logic busy;
  logic done;
  logic wr_err;
  logic start_err;
  logic coe_vld;
  logic coe_sop;
  logic [COE_WDTH-1:0] coe_din;
  logic coe_load;
  logic [31:0] coe_fir_dec;
  modport master (
    output host_wr_en, host_wr_addr, host_wr_data, host_dec, host_start,
    input busy, done, wr_err, start_err, coe_vld, coe_sop, coe_din, coe_load, coe_fir_dec
  );
  modport slave (
    input host_wr_en, host_wr_addr, host_wr_data, host_dec, host_start,
    output busy, done, wr_err, start_err, coe_vld, coe_sop, coe_din, coe_load, coe_fir_dec
  );
endinterface

// File: rtl/fir_coe_buf.sv
// fir_coe_buf: coefficient register file with range-checked write port and one registered read port
module fir_coe_buf #(
  parameter int DEPTH = 26,
  parameter int WDTH = 29,
  parameter int AW = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic wr_lock,
  input  logic [AW-1:0] wr_addr,
  input  logic [WDTH-1:0] wr_data,
  input  logic rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [WDTH-1:0] rd_data,
  output logic wr_err
);
  logic [WDTH-1:0] mem [DEPTH];
  logic wr_ok;
  assign wr_ok = wr_en && !wr_lock && ({1'b0, wr_addr} < (AW + 1)'(DEPTH));
  // a write landing in the same cycle as the read is forwarded so it reaches the burst
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
      wr_err <= 1'b0;
    end else begin
      if (wr_ok) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= (wr_ok && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
      wr_err <= wr_en && !wr_ok;
    end
endmodule

// File: rtl/fir_coe_send.sv
// fir_coe_send: serialises buffered FIR coefficients as one burst, then a settle gap, a load pulse and a hold window
module fir_coe_send import fir_coe_pkg::*; #(
  parameter int COE_NUM = COE_NUM_DEF,
  parameter int COE_WDTH = COE_WDTH_DEF,
  parameter int GAP_CYC = 4,
  parameter int HOLD_CYC = 16
) (
  input logic clk,
  input logic rst_n,
  fir_coe_send_if.slave bus
);
  localparam int N = coe_half(COE_NUM);
  localparam int AW = $clog2(N);
  localparam int TW = $clog2((GAP_CYC > HOLD_CYC ? GAP_CYC : HOLD_CYC) + 1);
  state_t state, nxt;
  logic [AW-1:0] wcnt, nxt_wcnt;
  logic [TW-1:0] tcnt, nxt_tcnt;
  logic start_ok;
  assign start_ok = bus.host_start && state == IDLE;
  always_comb begin
    nxt = state;
    nxt_wcnt = wcnt;
    nxt_tcnt = tcnt;
    case (state)
      IDLE: if (bus.host_start) begin nxt = SEND; nxt_wcnt = '0; end
      SEND: if (wcnt == AW'(N - 1)) begin nxt = GAP; nxt_tcnt = '0; end
            else nxt_wcnt = wcnt + 1'b1;
      GAP:  if (tcnt == TW'(GAP_CYC - 1)) nxt = LOAD;
            else nxt_tcnt = tcnt + 1'b1;
      LOAD: begin nxt = HOLD; nxt_tcnt = '0; end
      HOLD: if (tcnt == TW'(HOLD_CYC - 1)) nxt = IDLE;
            else nxt_tcnt = tcnt + 1'b1;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      wcnt <= '0;
      tcnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.start_err <= 1'b0;
      bus.coe_vld <= 1'b0;
      bus.coe_sop <= 1'b0;
      bus.coe_load <= 1'b0;
      bus.coe_fir_dec <= '0;
    end else begin
      state <= nxt;
      wcnt <= nxt_wcnt;
      tcnt <= nxt_tcnt;
      bus.busy <= nxt != IDLE;
      bus.done <= nxt == HOLD && nxt_tcnt == TW'(HOLD_CYC - 1);
      bus.start_err <= bus.host_start && state != IDLE;
      bus.coe_vld <= nxt == SEND;
      bus.coe_sop <= start_ok;
      bus.coe_load <= nxt == LOAD;
      if (start_ok) bus.coe_fir_dec <= bus.host_dec;
    end
  fir_coe_buf #(.DEPTH(N), .WDTH(COE_WDTH), .AW(AW)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(bus.host_wr_en),
    .wr_lock(state == SEND),
    .wr_addr(bus.host_wr_addr),
    .wr_data(bus.host_wr_data),
    .rd_en(nxt == SEND),
    .rd_addr(nxt_wcnt),
    .rd_data(bus.coe_din),
    .wr_err(bus.wr_err)
  );
endmodule

// File: tb/tb_fir_coe_send.sv
// tb_fir_coe_send: directed bursts with hand-derived timing and a host-side coefficient image
module tb_fir_coe_send;
  import fir_coe_pkg::*;
  localparam int N = coe_half(COE_NUM_DEF);
  localparam int AW = $clog2(N);
  localparam int GAP_CYC = 4;
  localparam int HOLD_CYC = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [COE_WDTH_DEF-1:0] model [N];
  fir_coe_send_if bus ();
  fir_coe_send #(.GAP_CYC(GAP_CYC), .HOLD_CYC(HOLD_CYC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic write_word(input int addr, input logic [COE_WDTH_DEF-1:0] data, input logic exp_err);
    bus.host_wr_en = 1'b1;
    bus.host_wr_addr = AW'(addr);
    bus.host_wr_data = data;
    tick;
    bus.host_wr_en = 1'b0;
    chk("wr_err", 32'(bus.wr_err), 32'(exp_err));
    if (!exp_err) model[addr] = data;
  endtask
  // mode: 0 plain, 1 start during SEND, 2 write during SEND, 3 write addr 0 with the start
  task automatic run_burst(input logic [31:0] dec, input int mode);
    bus.host_start = 1'b1;
    bus.host_dec = dec;
    if (mode == 3) begin
      bus.host_wr_en = 1'b1;
      bus.host_wr_addr = '0;
      bus.host_wr_data = 29'h55;
      model[0] = 29'h55;
    end
    for (int c = 1; c <= N + GAP_CYC + HOLD_CYC + 2; c++) begin
      tick;
      bus.host_start = 1'b0;
      bus.host_wr_en = 1'b0;
      chk("ctl", 32'({bus.busy, bus.coe_vld, bus.coe_sop, bus.coe_load, bus.done, bus.wr_err, bus.start_err}),
          32'({c <= N + GAP_CYC + HOLD_CYC + 1, c <= N, c == 1, c == N + GAP_CYC + 1,
               c == N + GAP_CYC + HOLD_CYC + 1, mode == 2 && c == 6, mode == 1 && c == 6}));
      if (c <= N) chk("din", 32'(bus.coe_din), 32'(model[c-1]));
      if (c == N + GAP_CYC) chk("din_hold", 32'(bus.coe_din), 32'(model[N-1]));
      if (c == 1 || c == N + GAP_CYC + HOLD_CYC + 2) chk("dec", bus.coe_fir_dec, dec);
      if (c == 5 && mode == 1) begin
        bus.host_start = 1'b1;
        bus.host_dec = 32'h77;
      end
      if (c == 5 && mode == 2) begin
        bus.host_wr_en = 1'b1;
        bus.host_wr_addr = AW'(3);
        bus.host_wr_data = 29'h1ABCDEF;
      end
    end
  endtask
  initial begin
    logic bad;
    bus.host_wr_en = 1'b0;
    bus.host_wr_addr = '0;
    bus.host_wr_data = '0;
    bus.host_dec = '0;
    bus.host_start = 1'b0;
    for (int k = 0; k < N; k++) model[k] = '0;
    repeat (3) tick;
    chk("rst_ctl", 32'({bus.busy, bus.done, bus.wr_err, bus.start_err, bus.coe_vld, bus.coe_sop, bus.coe_load}), 32'h0);
    chk("rst_din", 32'(bus.coe_din), 32'h0);
    chk("rst_dec", bus.coe_fir_dec, 32'h0);
    rst_n = 1'b1;
    tick;
    for (int k = 0; k < N; k++) write_word(k, 29'(k + 32'h100), 1'b0);
    run_burst(32'd8, 0);
    run_burst(32'd9, 1);
    run_burst(32'd10, 2);
    write_word(N, 29'h1234, 1'b1);
    run_burst(32'd11, 0);
    run_burst(32'd12, 3);
    bus.host_start = 1'b1;
    bus.host_dec = 32'd5;
    for (int c = 1; c <= 11; c++) begin
      tick;
      bus.host_start = 1'b0;
    end
    chk("pre_rst_din", 32'(bus.coe_din), 32'(model[10]));
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("abort_ctl", 32'({bus.busy, bus.coe_vld, bus.coe_sop, bus.coe_load}), 32'h0);
    chk("abort_dec", bus.coe_fir_dec, 32'h0);
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick;
      bad |= bus.coe_vld | bus.coe_load | bus.busy;
    end
    chk("no_load_after_abort", 32'(bad), 32'h0);
    for (int k = 0; k < N; k++) model[k] = '0;
    run_burst(32'd6, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
